// File: rtl/fpu_arbiter.sv
// Round-robin scheduler sharing one non-pipelined FPU between two requesters.
// Each finished result is queued in its owner's response FIFO.
module fpu_arbiter #(
  parameter int FPU_LAT   = 2,
  parameter int RSP_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [3:0]  req_sel,
  input  logic [3:0]  req_rmode,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [63:0] rsp_y,
  output logic [1:0]  rsp_error,
  output logic [1:0]  rsp_overflow,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_sel,
  output logic [1:0]  fpu_round_mode,
  output logic        fpu_start,
  input  logic [31:0] fpu_y,
  input  logic        fpu_error,
  input  logic        fpu_overflow,
  output logic        busy
);
  localparam int CW = $clog2(FPU_LAT + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int NW = $clog2(RSP_DEPTH + 1);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t        r_state;
  logic          r_rr_ptr;
  logic          r_owner;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_fpu_a;
  logic [31:0]   r_fpu_b;
  logic [1:0]    r_fpu_sel;
  logic [1:0]    r_fpu_rmode;
  logic          r_fpu_start;
  logic          r_busy;

  logic [1:0]    w_space;
  logic [1:0]    w_elig;
  logic [1:0]    w_grant;
  logic          w_gidx;
  logic          w_capture;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_capture = (r_state == EXEC) && (r_cnt == CW'(1));
  assign w_elig    = req_valid & w_space;

  always_comb begin
    w_grant = 2'b00;
    if (r_state == IDLE) begin
      if (w_elig == 2'b11) w_grant = r_rr_ptr ? 2'b10 : 2'b01;
      else                 w_grant = w_elig;
    end
  end

  assign w_gidx    = w_grant[1];
  assign req_ready = w_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= 1'b0;
      r_owner     <= 1'b0;
      r_cnt       <= '0;
      r_fpu_a     <= '0;
      r_fpu_b     <= '0;
      r_fpu_sel   <= '0;
      r_fpu_rmode <= '0;
      r_fpu_start <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant != 2'b00) begin
            r_fpu_a     <= w_gidx ? req_a[63:32]    : req_a[31:0];
            r_fpu_b     <= w_gidx ? req_b[63:32]    : req_b[31:0];
            r_fpu_sel   <= w_gidx ? req_sel[3:2]    : req_sel[1:0];
            r_fpu_rmode <= w_gidx ? req_rmode[3:2]  : req_rmode[1:0];
            r_fpu_start <= 1'b1;
            r_busy      <= 1'b1;
            r_owner     <= w_gidx;
            r_cnt       <= CW'(FPU_LAT);
            r_rr_ptr    <= ~w_gidx;
            r_state     <= EXEC;
          end
        end
        EXEC: begin
          // Operands stay on the FPU bus after completion; only start drops.
          if (r_cnt == CW'(1)) begin
            r_fpu_start <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign fpu_a          = r_fpu_a;
  assign fpu_b          = r_fpu_b;
  assign fpu_sel        = r_fpu_sel;
  assign fpu_round_mode = r_fpu_rmode;
  assign fpu_start      = r_fpu_start;
  assign busy           = r_busy;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [33:0]   r_mem [RSP_DEPTH];
      logic [PW-1:0] r_rd;
      logic [PW-1:0] r_wr;
      logic [NW-1:0] r_count;
      logic          w_push;
      logic          w_pop;
      logic          w_nonempty;
      logic [33:0]   w_head;

      assign w_push     = w_capture && (r_owner == 1'(gi));
      assign w_nonempty = (r_count != '0);
      assign w_pop      = rsp_ready[gi] && w_nonempty;
      assign w_space[gi] = (r_count < NW'(RSP_DEPTH));

      always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= {fpu_y, fpu_error, fpu_overflow};
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_rd    <= '0;
          r_wr    <= '0;
          r_count <= '0;
        end else begin
          if (w_push) r_wr <= f_next(r_wr);
          if (w_pop)  r_rd <= f_next(r_rd);
          if (w_push && !w_pop)      r_count <= r_count + 1'b1;
          else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
      end

      // Storage is not reset, so the head is masked while the FIFO is empty.
      assign w_head = w_nonempty ? r_mem[r_rd] : '0;
      assign rsp_valid[gi]      = w_nonempty;
      assign rsp_y[32*gi +: 32] = w_head[33:2];
      assign rsp_error[gi]      = w_head[1];
      assign rsp_overflow[gi]   = w_head[0];
    end
  endgenerate

endmodule

// File: tb/tb_fpu_arbiter.sv
// Self-checking bench for fpu_arbiter: cycle-level scoreboard plus directed scenarios.
module tb_fpu_arbiter;
  localparam int FPU_LAT   = 2;
  localparam int RSP_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready;
  logic [63:0] req_a, req_b;
  logic [3:0]  req_sel, req_rmode;
  logic [1:0]  rsp_valid, rsp_ready;
  logic [63:0] rsp_y;
  logic [1:0]  rsp_error, rsp_overflow;
  logic [31:0] fpu_a, fpu_b;
  logic [1:0]  fpu_sel, fpu_round_mode;
  logic        fpu_start;
  logic [31:0] fpu_y;
  logic        fpu_error, fpu_overflow;
  logic        busy;

  always #5 clk = ~clk;

  fpu_arbiter #(.FPU_LAT(FPU_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_rmode(req_rmode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_error(rsp_error), .rsp_overflow(rsp_overflow),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sel(fpu_sel), .fpu_round_mode(fpu_round_mode),
    .fpu_start(fpu_start), .fpu_y(fpu_y), .fpu_error(fpu_error),
    .fpu_overflow(fpu_overflow), .busy(busy)
  );

  // Toy FPU: {y, error, overflow} as a pure function of the operation.
  function automatic logic [33:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] sel, input logic [1:0] rm);
    if (sel == 2'b11) return {32'h7F800000, 2'b11};
    if (sel == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 2'b00};
    return {a ^ (b << 1) ^ {28'h0, sel, rm}, a[0], b[0]};
  endfunction

  // The result is only valid in the last cycle of the start window; garbage otherwise.
  int          s_cnt;
  logic [33:0] f_res;
  always @(posedge clk or posedge reset) begin
    if (reset)          s_cnt <= 0;
    else if (fpu_start) s_cnt <= s_cnt + 1;
    else                s_cnt <= 0;
  end
  always_comb begin
    f_res = {32'hDEADBEEF, 2'b10};
    if (fpu_start && s_cnt == FPU_LAT - 1) f_res = fpu_fn(fpu_a, fpu_b, fpu_sel, fpu_round_mode);
  end
  assign {fpu_y, fpu_error, fpu_overflow} = f_res;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    end
  endtask

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard state: remaining start cycles, turn pointer, in-flight op, per-FIFO queues.
  int          m_left;
  logic        m_rr, m_owner;
  logic [31:0] m_a, m_b;
  logic [1:0]  m_sel, m_rm;
  logic [33:0] m_q0[$];
  logic [33:0] m_q1[$];
  int          g_who[$];
  int          g_cyc[$];

  initial begin
    logic [1:0] elig, exp_g, exp_v;
    m_left = 0; m_rr = 1'b0; m_owner = 1'b0;
    m_a = '0; m_b = '0; m_sel = '0; m_rm = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_left = 0; m_rr = 1'b0; m_owner = 1'b0;
        m_a = '0; m_b = '0; m_sel = '0; m_rm = '0;
        m_q0.delete(); m_q1.delete();
        chk("rst_ctrl", {busy, fpu_start, rsp_valid, req_ready, fpu_sel, fpu_round_mode}, 64'd0);
        chk("rst_ops", {fpu_a, fpu_b}, 64'd0);
        chk("rst_rsp", rsp_y, 64'd0);
      end else begin
        elig[0] = req_valid[0] && (m_q0.size() < RSP_DEPTH);
        elig[1] = req_valid[1] && (m_q1.size() < RSP_DEPTH);
        exp_g = 2'b00;
        if (m_left == 0) exp_g = (elig == 2'b11) ? (m_rr ? 2'b10 : 2'b01) : elig;
        exp_v = {m_q1.size() > 0, m_q0.size() > 0};
        chk("req_ready", req_ready, exp_g);
        chk("busy_start", {busy, fpu_start}, (m_left > 0) ? 2'b11 : 2'b00);
        chk("fpu_ops", {fpu_a, fpu_b}, {m_a, m_b});
        chk("fpu_ctl", {fpu_sel, fpu_round_mode}, {m_sel, m_rm});
        chk("rsp_valid", rsp_valid, exp_v);
        if (exp_v[0]) chk("rsp0_head", {rsp_y[31:0], rsp_error[0], rsp_overflow[0]}, m_q0[0]);
        if (exp_v[1]) chk("rsp1_head", {rsp_y[63:32], rsp_error[1], rsp_overflow[1]}, m_q1[0]);
        if (req_ready != 2'b00) begin
          g_who.push_back(req_ready[1] ? 1 : 0);
          g_cyc.push_back(cyc);
        end
        // Advance the model across the coming rising edge.
        if (rsp_ready[0] && m_q0.size() > 0) void'(m_q0.pop_front());
        if (rsp_ready[1] && m_q1.size() > 0) void'(m_q1.pop_front());
        if (m_left > 0) begin
          if (m_left == 1) begin
            if (m_owner) m_q1.push_back(fpu_fn(m_a, m_b, m_sel, m_rm));
            else         m_q0.push_back(fpu_fn(m_a, m_b, m_sel, m_rm));
          end
          m_left--;
        end else if (exp_g != 2'b00) begin
          m_owner = exp_g[1];
          m_rr    = ~exp_g[1];
          m_left  = FPU_LAT;
          m_a     = m_owner ? req_a[63:32]     : req_a[31:0];
          m_b     = m_owner ? req_b[63:32]     : req_b[31:0];
          m_sel   = m_owner ? req_sel[3:2]     : req_sel[1:0];
          m_rm    = m_owner ? req_rmode[3:2]   : req_rmode[1:0];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] sel, input logic [1:0] rm);
    req_a[32*i +: 32]   = a;
    req_b[32*i +: 32]   = b;
    req_sel[2*i +: 2]   = sel;
    req_rmode[2*i +: 2] = rm;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_a = '0; req_b = '0; req_sel = '0; req_rmode = '0;
    step(); step();
    reset = 1'b0;
    step();
    chk("idle_after_reset", {busy, fpu_start, rsp_valid, req_ready}, 64'd0);

    // Single operation: 1.0 + 2.0
    set_req(0, 32'h3F800000, 32'h40000000, 2'b00, 2'b00);
    req_valid = 2'b01; #1;
    chk("t1_grant_comb", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    chk("t1_exec_t", {fpu_start, busy, req_ready}, 4'b1100);
    step();
    chk("t1_exec_t1", {fpu_start, rsp_valid}, 3'b100);
    step();
    chk("t1_done", {fpu_start, busy, rsp_valid}, 4'b0001);
    chk("t1_y", rsp_y[31:0], 32'h40400000);
    set_req(0, 32'h11111111, 32'h22222222, 2'b10, 2'b01);
    req_valid = 2'b01; #1;
    chk("t1_next_grant", req_ready, 2'b01);
    step();
    req_valid = 2'b00; rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    step();
    chk("t1_second", {rsp_valid[0], rsp_y[31:0], rsp_error[0], rsp_overflow[0]},
        {1'b1, 32'h5555555C, 1'b1, 1'b0});
    rsp_ready = 2'b01; step(); rsp_ready = 2'b00;

    // Error/overflow flags pass through to requester 1
    set_req(1, 32'h40000000, 32'h00000000, 2'b11, 2'b10);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    step(); step();
    chk("flags", {rsp_valid[1], rsp_y[63:32], rsp_error[1], rsp_overflow[1]},
        {1'b1, 32'h7F800000, 2'b11});
    rsp_ready = 2'b10; step(); rsp_ready = 2'b00;

    // Contention after reset: alternating grants
    reset = 1'b1; step(); reset = 1'b0; step();
    g_who.delete(); g_cyc.delete();
    set_req(0, 32'h0A0B0C0D, 32'h01020304, 2'b01, 2'b10);
    set_req(1, 32'hA0B0C0D1, 32'h10203040, 2'b10, 2'b11);
    rsp_ready = 2'b11; req_valid = 2'b11;
    for (int k = 0; k < 40 && g_who.size() < 4; k++) begin
      step();
      req_a = req_a + 64'h0000_0001_0000_0001;
    end
    req_valid = 2'b00;
    chk("cont_count", g_who.size(), 4);
    if (g_who.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("cont_order", g_who[k], k % 2);
        if (k > 0) chk("cont_spacing", g_cyc[k] - g_cyc[k-1], FPU_LAT + 1);
      end
    end
    repeat (4) step();

    // Backpressure on requester 1
    rsp_ready = 2'b00; g_who.delete(); g_cyc.delete();
    set_req(1, 32'h12345678, 32'h0F0F0F0F, 2'b00, 2'b01);
    req_valid = 2'b10;
    repeat (7) step();
    chk("bp_stall", {req_ready, busy, rsp_valid[1]}, 4'b0001);
    chk("bp_accepted", g_who.size(), 2);

    // Isolation: FIFO1 full, requester 0 keeps being served
    g_who.delete(); g_cyc.delete();
    set_req(0, 32'h00C0FFEE, 32'h0BADF00D, 2'b10, 2'b00);
    req_valid = 2'b11; rsp_ready = 2'b01;
    repeat (10) step();
    chk("iso_r1", req_ready[1], 1'b0);
    chk("iso_count", g_who.size(), 4);
    for (int k = 0; k < g_who.size(); k++) begin
      chk("iso_who", g_who[k], 0);
      if (k > 0) chk("iso_spacing", g_cyc[k] - g_cyc[k-1], FPU_LAT + 1);
    end
    req_valid = 2'b00;
    repeat (3) step();

    // One pop on FIFO1 lets the stalled third op through
    req_valid = 2'b10; rsp_ready = 2'b10; #1;
    chk("bp_still_blocked", req_ready, 2'b00);
    step();
    rsp_ready = 2'b00; #1;
    chk("bp_resume", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    chk("bp_busy", busy, 1'b1);
    rsp_ready = 2'b11;
    repeat (6) step();
    rsp_ready = 2'b00;

    // Reset one cycle into an operation
    set_req(0, 32'h76543210, 32'h01234567, 2'b01, 2'b11);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    reset = 1'b1; #1;
    chk("rst_mid_ctrl", {fpu_start, busy, rsp_valid, req_ready, fpu_sel, fpu_round_mode}, 64'd0);
    chk("rst_mid_ops", {fpu_a, fpu_b}, 64'd0);
    step();
    reset = 1'b0;
    repeat (3) step();
    chk("rst_no_rsp", rsp_valid, 2'b00);
    set_req(1, 32'h3C3C3C3C, 32'h5A5A5A5A, 2'b10, 2'b00);
    req_valid = 2'b11; #1;
    chk("rst_rr0", req_ready, 2'b01);
    step();
    req_valid = 2'b00; rsp_ready = 2'b11;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
Two-requester round-robin scheduler that shares one non-pipelined FPU between two clients. It accepts operation requests through valid/ready handshakes and drives the FPU operand, select and start signals. It counts the fixed FPU latency and captures the result. Each result is returned through a per-requester response FIFO that has its own valid/ready handshake. It sits between client blocks and the FPU in the FPU subsystem.

Parameters:
FPU_LAT, 2, cycles from the first fpu_start-high cycle to the cycle in which fpu_y/fpu_error/fpu_overflow are valid (min 1)
RSP_DEPTH, 2, entries per requester response FIFO (min 1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  2  bit i: requester i has an operation
req_ready  out  2  bit i: requester i granted this cycle (combinational)
req_a  in  64  [32i+31:32i] operand A of requester i
req_b  in  64  operand B, same packing
req_sel  in  4  [2i+1:2i] op: 00 add, 01 sub, 10 mul, 11 div
req_rmode  in  4  [2i+1:2i] rounding mode
rsp_valid  out  2  bit i: response FIFO i non-empty
rsp_ready  in  2  bit i: requester i pops head
rsp_y  out  64  head result of FIFO i, packed like req_a
rsp_error  out  2  head error flag of FIFO i
rsp_overflow  out  2  head overflow flag of FIFO i
fpu_a  out  32  operand A to FPU
fpu_b  out  32  operand B to FPU
fpu_sel  out  2  op select to FPU
fpu_round_mode  out  2  rounding mode to FPU
fpu_start  out  1  high throughout execution
fpu_y  in  32  FPU result
fpu_error  in  1  FPU error flag
fpu_overflow  in  1  FPU overflow flag
busy  out  1  high while state is EXEC

Behaviour:
- Clock is clk. Reset is asynchronous and active-high on port reset.
- Reset values: state IDLE, rr_ptr 0, both FIFOs empty, fpu_start 0, fpu_a/fpu_b/fpu_sel/fpu_round_mode 0, busy 0. Therefore rsp_valid=0 and rsp_y/rsp_error/rsp_overflow=0.
- Eligibility: requester i is eligible when req_valid[i]=1 and fifo_count[i] < RSP_DEPTH.
- Arbitration applies only in IDLE. If both requesters are eligible, grant rr_ptr. If one is eligible, grant it. req_ready=00 in EXEC.
- req_ready is a one-hot grant. At most one grant per cycle. req_ready never depends on rsp_ready.
- Grant at edge t, i.e. handshake req_valid[i]&req_ready[i]:
  - Register the operands, sel and rmode onto fpu_*.
  - fpu_start<=1, owner<=i, cnt<=FPU_LAT, state<=EXEC, rr_ptr<=~i.
- EXEC: fpu_* outputs are held stable and cnt decrements each edge.
- At the edge where cnt==1:
  - Push {fpu_y, fpu_error, fpu_overflow} into FIFO[owner].
  - fpu_start<=0, state<=IDLE.
  - fpu_a/fpu_b/fpu_sel/fpu_round_mode keep their last values.
- Timing: handshake at edge t gives fpu_start high for cycles t..t+FPU_LAT-1 (FPU_LAT cycles) and rsp_valid visible from edge t+FPU_LAT.
- The next grant is possible at edge t+FPU_LAT+1. Peak throughput is 1 op per FPU_LAT+1 cycles.
- Only one operation is ever in flight, so the owner FIFO always has space at capture (guaranteed by eligibility).
- FIFO i:
  - Head is presented on rsp_* when non-empty.
  - A pop (rsp_valid&rsp_ready) and a push on the same edge are both performed; count is unchanged.
  - A pop with an empty FIFO is ignored.
  - FIFO storage wraps modulo RSP_DEPTH.
- A full FIFO i blocks only requester i. The other requester continues to be served.
- Reset asserted mid-EXEC: the in-flight op is dropped and FIFO contents are discarded. No response is produced for the dropped op after reset release.
- fpu_error/fpu_overflow are passed through verbatim. The arbiter does not interpret them.

Test Plan:
- Single op, FPU_LAT=2, model Y=A+B: req0 A=0x3F800000 B=0x40000000 sel=00 at edge t -> fpu_start high cycles t..t+1, busy=1, req_ready=00 during EXEC; rsp_valid[0]=1, rsp_y[31:0]=0x40400000 from t+2; next grant at t+3.
- Contention: both requesters hold valid for 4 ops after reset -> grant order 0,1,0,1 with spacing FPU_LAT+1; responses routed to matching FIFOs in order.
- Backpressure: RSP_DEPTH=2, rsp_ready[1]=0, requester 1 streams 3 ops with requester 0 idle -> two accepted, third stalls with req_ready[1]=0 and busy=0; one pop -> third accepted next IDLE cycle.
- Isolation: FIFO1 full, req0 valid continuously -> requester 0 granted every FPU_LAT+1 cycles; req_ready[1] stays 0.
- Flags: model returns fpu_error=1, fpu_overflow=1, Y=0x7F800000 for sel=11 -> rsp_error[i]=1, rsp_overflow[i]=1, rsp_y=0x7F800000.
- Reset mid-EXEC one cycle after grant -> all outputs 0 immediately; no rsp_valid for that op after release; next request served normally, starting with rr_ptr=0.
